// File: rtl/ntt_pkg.sv
// Shared types and default sizes for the NTT job scheduler.
package ntt_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned NumLanes  = 16;
  // Bit width of one lane slice: lane k lives at [k*LaneWidth +: LaneWidth].
  localparam int unsigned LaneWidth = DataWidth;
  localparam int unsigned BusWidth  = NumLanes * LaneWidth;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/ntt_sched_if.sv
// Requester, core and response signals for the NTT scheduler.
interface ntt_sched_if #(
  parameter int unsigned DATA_WIDTH = ntt_pkg::DataWidth,
  parameter int unsigned N          = ntt_pkg::NumLanes
);
  localparam int unsigned BusW = N * DATA_WIDTH;

  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic            req0_inv, req1_inv;
  logic [BusW-1:0] req0_data, req1_data;
  logic            core_load, core_inv;
  logic [BusW-1:0] core_din, core_dout;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_inv;
  logic [BusW-1:0] rsp_data;
  logic            busy;

  // Scheduler side.
  modport master (
    input  req0_valid, req1_valid, req0_inv, req1_inv, req0_data, req1_data,
    input  core_dout, rsp_ready,
    output req0_ready, req1_ready, core_load, core_inv, core_din,
    output rsp_valid, rsp_id, rsp_inv, rsp_data, busy
  );

  // Requester / core / consumer side.
  modport slave (
    output req0_valid, req1_valid, req0_inv, req1_inv, req0_data, req1_data,
    output core_dout, rsp_ready,
    input  req0_ready, req1_ready, core_load, core_inv, core_din,
    input  rsp_valid, rsp_id, rsp_inv, rsp_data, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; pointer remembers the last accepted grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic last_q;  // 1 = requester 1 was granted last

  // One-hot grant; on contention the requester not granted last wins.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (|gnt_o) begin
      last_q <= gnt_o[1];
    end
  end
endmodule

// File: rtl/ntt_sched.sv
// Schedules jobs from two requesters onto one shared NTT core, one at a time.
module ntt_sched
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned N          = NumLanes,
  parameter int unsigned CORE_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  ntt_sched_if.master bus
);
  localparam int unsigned BusW = N * DATA_WIDTH;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [BusW-1:0] job_data_q, rsp_data_q;
  logic            job_inv_q, job_id_q;
  logic            rsp_valid_q, rsp_id_q, rsp_inv_q, core_load_q, busy_q;

  logic [1:0] req, gnt;
  logic       arb_en, accept, win_id;

  assign req    = {bus.req1_valid, bus.req0_valid};
  assign arb_en = (state_q == StIdle) && !rst;

  rr_arb2 u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign accept = |gnt;
  assign win_id = gnt[1];

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.core_load  = core_load_q;
  assign bus.core_inv   = job_inv_q;
  assign bus.core_din   = job_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_inv    = rsp_inv_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = busy_q;

  // Job FSM with registered outputs; latched job drives the core until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      job_data_q  <= '0;
      job_inv_q   <= 1'b0;
      job_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_inv_q   <= 1'b0;
      core_load_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      core_load_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            job_data_q  <= win_id ? bus.req1_data : bus.req0_data;
            job_inv_q   <= win_id ? bus.req1_inv : bus.req0_inv;
            job_id_q    <= win_id;
            core_load_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= 4'(CORE_LAT - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= bus.core_dout;
            rsp_id_q    <= job_id_q;
            rsp_inv_q   <= job_inv_q;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          // Return to IDLE only; no accept in the handshake cycle.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: doc/ntt_sched.md
NTT_SCHED -- requirements
Module: ntt_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one coefficient lane.
REQ-002 Parameter N, default 16: number of lanes per transform; each bus is N*DATA_WIDTH bits with lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-003 Parameter CORE_LAT, default 2: number of cycles from core_load assertion to the cycle core_dout is valid; legal range is 1..15.
REQ-004 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Ports req0_valid / req1_valid, input, 1 each: requester i has a transform job pending.
REQ-007 Ports req0_ready / req1_ready, output, 1 each: the job is accepted in a cycle where valid and ready are both 1.
REQ-008 Ports req0_inv / req1_inv, input, 1 each: job mode, 0 = forward NTT, 1 = inverse NTT.
REQ-009 Ports req0_data / req1_data, input, N*DATA_WIDTH each: job coefficients.
REQ-010 Port core_load, output, 1: one-cycle pulse that loads core_din into the shared transform core.
REQ-011 Port core_inv, output, 1: mode presented to the core.
REQ-012 Port core_din, output, N*DATA_WIDTH: coefficients presented to the core.
REQ-013 Port core_dout, input, N*DATA_WIDTH: core result.
REQ-014 Port rsp_valid, output, 1: result available.
REQ-015 Port rsp_ready, input, 1: the consumer accepts the result.
REQ-016 Ports rsp_id (output, 1), rsp_inv (output, 1), rsp_data (output, N*DATA_WIDTH): originating requester, job mode, and transform result.
REQ-017 Port busy, output, 1: asserted whenever the state is not IDLE.

Function
REQ-018 The FSM has four states: IDLE, ISSUE, WAIT and RESP; only one job is in flight at a time.
REQ-019 In IDLE with at least one valid request:
- exactly one req_ready is driven combinationally to the arbitration winner;
- the winner's data, inv and id are latched;
- the next state is ISSUE.
REQ-020 Arbitration is round-robin:
- a lone valid request always wins;
- when both are valid, the requester not granted last wins;
- the last-grant pointer updates only on an accepted job.
REQ-021 Both req_ready outputs are 0 in every state except IDLE.
REQ-022 ISSUE lasts exactly one cycle:
- core_load = 1, and core_din and core_inv carry the latched job;
- a WAIT counter is loaded with CORE_LAT-1.
REQ-023 In WAIT:
- core_din and core_inv are held stable;
- the counter decrements each cycle;
- in the cycle the counter is 0, core_dout is captured into rsp_data and the next state is RESP.
REQ-024 Timing: a job accepted at cycle T gives core_load at T+1, captures core_dout at T+1+CORE_LAT, and asserts rsp_valid from T+2+CORE_LAT.
REQ-025 In RESP:
- rsp_valid is held at 1, and rsp_data, rsp_id and rsp_inv are held stable, until rsp_ready = 1;
- on that handshake the next state is IDLE.
REQ-026 A new job is not accepted in the cycle the RESP handshake occurs; the minimum job spacing is CORE_LAT+3 cycles.
REQ-027 core_load is 0 in every state other than ISSUE.
REQ-028 Requests that drop valid without being granted have no effect.

Reset
REQ-029 When rst = 1 at a rising edge:
- the state becomes IDLE;
- the counter and the latched job are cleared to 0;
- the last-grant pointer is set to 1, so requester 0 wins the first contention.
REQ-030 Reset values: rsp_valid, rsp_id, rsp_inv, rsp_data, core_load, core_inv, core_din and busy are all 0.
REQ-031 A reset in ISSUE, WAIT or RESP aborts the in-flight job with no response; a later core_dout is ignored.
REQ-032 While rst = 1, both req_ready outputs are 0.

Structure
REQ-033 The state encoding, DATA_WIDTH and N defaults, and the lane-slicing width constant belong in the shared package ntt_pkg.
REQ-034 The two-requester round-robin arbiter, including its pointer, is the single sub-module rr_arb2.

Verification
(Bench uses CORE_LAT=2 and a stub core whose core_dout equals core_din with lane 0 incremented by 1 and core_inv added, registered CORE_LAT cycles.)
REQ-035 Single job: req0 valid with lane0 = 5, inv = 0, accepted at T -> core_load at T+1, rsp_valid at T+4, rsp_id = 0, rsp_inv = 0, rsp lane0 = 6.
REQ-036 Contention: both requests held valid with rsp_ready = 1 -> grant order 0,1,0,1 with accepts spaced 5 cycles apart.
REQ-037 Backpressure: rsp_ready held low for 3 cycles in RESP -> rsp_valid and rsp_data stable, both req_ready = 0, busy = 1.
REQ-038 Inverse mode: req1 with inv = 1 and lane0 = 16 -> core_inv = 1 throughout ISSUE and WAIT, rsp_inv = 1, rsp lane0 = 18, rsp_id = 1.
REQ-039 Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0 next cycle and no response; a subsequent simultaneous request grants requester 0.
